// File: rtl/vdc_host_master.sv
// vdc_host_master
// Bus-cycle initiator for the EPOCH TV-1 host port. A single request/ack
// transaction becomes a chip-select / strobe cycle whose setup, strobe and
// hold phases are each counted in CE ticks.
//
// Ports:
//   CLK, RESB        clock, synchronous active-low reset
//   CE               clock enable pacing the bus phases (not the accept/ack)
//   REQ, REQ_WE      request level (sampled in IDLE only), 1 = write
//   REQ_A, REQ_D     request address / write data
//   ACK              one-CLK completion pulse
//   BUSY             high whenever not IDLE
//   RD_DATA          last captured read data
//   A, DB_O, DB_OE   address, write data and data drive enable to the VDC
//   DB_I             read data from the VDC
//   RDB, WRB, CSB    active-low read strobe, write strobe, chip select
module vdc_host_master #(
  parameter int unsigned SETUP_CYC  = 1,
  parameter int unsigned STROBE_CYC = 2,
  parameter int unsigned HOLD_CYC   = 1
) (
  input  logic        CLK,
  input  logic        RESB,
  input  logic        CE,
  input  logic        REQ,
  input  logic        REQ_WE,
  input  logic [12:0] REQ_A,
  input  logic [7:0]  REQ_D,
  output logic        ACK,
  output logic        BUSY,
  output logic [7:0]  RD_DATA,
  output logic [12:0] A,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  input  logic [7:0]  DB_I,
  output logic        RDB,
  output logic        WRB,
  output logic        CSB
);

  localparam int unsigned MAX_SS = (SETUP_CYC > STROBE_CYC) ? SETUP_CYC : STROBE_CYC;
  localparam int unsigned MAX_P  = (MAX_SS > HOLD_CYC) ? MAX_SS : HOLD_CYC;
  localparam int unsigned CW     = (MAX_P > 1) ? $clog2(MAX_P + 1) : 1;

  localparam logic [CW-1:0] C_SETUP  = CW'(SETUP_CYC - 1);
  localparam logic [CW-1:0] C_STROBE = CW'(STROBE_CYC - 1);
  localparam logic [CW-1:0] C_HOLD   = CW'(HOLD_CYC - 1);
  localparam logic [CW-1:0] C_ONE    = CW'(1);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_SETUP  = 2'd1;
  localparam logic [1:0] S_STROBE = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  logic [1:0]    r_state;
  logic [CW-1:0] r_cnt;
  logic          r_we;
  logic          r_ack;
  logic          r_busy;
  logic [7:0]    r_rd_data;
  logic [12:0]   r_a;
  logic [7:0]    r_db_o;
  logic          r_db_oe;
  logic          r_rdb;
  logic          r_wrb;
  logic          r_csb;
  logic          w_cnt_zero;

  assign w_cnt_zero = (r_cnt == '0);

  always_ff @(posedge CLK) begin
    if (!RESB) begin
      r_state   <= S_IDLE;
      r_cnt     <= '0;
      r_we      <= 1'b0;
      r_ack     <= 1'b0;
      r_busy    <= 1'b0;
      r_rd_data <= '0;
      r_a       <= '0;
      r_db_o    <= '0;
      r_db_oe   <= 1'b0;
      r_rdb     <= 1'b1;
      r_wrb     <= 1'b1;
      r_csb     <= 1'b1;
    end else begin
      // ACK is a single-CLK pulse regardless of CE.
      r_ack <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Accept is not gated by CE so a request never waits for a tick.
          if (REQ) begin
            r_a     <= REQ_A;
            r_db_o  <= REQ_D;
            r_we    <= REQ_WE;
            r_csb   <= 1'b0;
            r_db_oe <= REQ_WE;
            r_busy  <= 1'b1;
            r_cnt   <= C_SETUP;
            r_state <= S_SETUP;
          end
        end
        S_SETUP: begin
          if (CE) begin
            if (!w_cnt_zero) begin
              r_cnt <= r_cnt - C_ONE;
            end else begin
              if (r_we) r_wrb <= 1'b0;
              else      r_rdb <= 1'b0;
              r_cnt   <= C_STROBE;
              r_state <= S_STROBE;
            end
          end
        end
        S_STROBE: begin
          if (CE) begin
            if (!w_cnt_zero) begin
              r_cnt <= r_cnt - C_ONE;
            end else begin
              // Capture on the strobe-release edge: DB_I reflects the
              // last strobe-low cycle.
              if (!r_we) r_rd_data <= DB_I;
              r_rdb   <= 1'b1;
              r_wrb   <= 1'b1;
              r_cnt   <= C_HOLD;
              r_state <= S_HOLD;
            end
          end
        end
        default: begin
          if (CE) begin
            if (!w_cnt_zero) begin
              r_cnt <= r_cnt - C_ONE;
            end else begin
              r_csb   <= 1'b1;
              r_db_oe <= 1'b0;
              r_busy  <= 1'b0;
              r_ack   <= 1'b1;
              r_state <= S_IDLE;
            end
          end
        end
      endcase
    end
  end

  assign ACK     = r_ack;
  assign BUSY    = r_busy;
  assign RD_DATA = r_rd_data;
  assign A       = r_a;
  assign DB_O    = r_db_o;
  assign DB_OE   = r_db_oe;
  assign RDB     = r_rdb;
  assign WRB     = r_wrb;
  assign CSB     = r_csb;

endmodule

// File: tb/tb_vdc_host_master.sv
module tb_vdc_host_master;

  logic        CLK = 1'b0;
  logic        RESB, CE, REQ, REQ_WE, b_REQ;
  logic [12:0] REQ_A;
  logic [7:0]  REQ_D, DB_I;

  logic        ACK, BUSY, DB_OE, RDB, WRB, CSB;
  logic [7:0]  RD_DATA, DB_O;
  logic [12:0] A;

  logic        b_ACK, b_BUSY, b_DB_OE, b_RDB, b_WRB, b_CSB;
  logic [7:0]  b_RD_DATA, b_DB_O;
  logic [12:0] b_A;

  int unsigned n_cmp = 0;
  int unsigned n_err = 0;
  int unsigned cyc   = 0;
  logic        ce_div = 1'b0;

  always #5 CLK = ~CLK;

  vdc_host_master dut (
    .CLK(CLK), .RESB(RESB), .CE(CE), .REQ(REQ), .REQ_WE(REQ_WE),
    .REQ_A(REQ_A), .REQ_D(REQ_D), .ACK(ACK), .BUSY(BUSY), .RD_DATA(RD_DATA),
    .A(A), .DB_O(DB_O), .DB_OE(DB_OE), .DB_I(DB_I), .RDB(RDB), .WRB(WRB), .CSB(CSB)
  );

  vdc_host_master #(.SETUP_CYC(1), .STROBE_CYC(1), .HOLD_CYC(1)) dut_b (
    .CLK(CLK), .RESB(RESB), .CE(CE), .REQ(b_REQ), .REQ_WE(REQ_WE),
    .REQ_A(REQ_A), .REQ_D(REQ_D), .ACK(b_ACK), .BUSY(b_BUSY), .RD_DATA(b_RD_DATA),
    .A(b_A), .DB_O(b_DB_O), .DB_OE(b_DB_OE), .DB_I(DB_I), .RDB(b_RDB), .WRB(b_WRB),
    .CSB(b_CSB)
  );

  typedef struct {
    logic        we;
    logic [12:0] a;
    logic [7:0]  d;
    logic [7:0]  dbi;
    logic [7:0]  exp_rd;
  } vec_t;

  vec_t vecs[4];

  // Advance one CLK; sample/drive 1 time unit after the edge.
  task automatic tick();
    @(posedge CLK);
    #1;
    cyc++;
    CE = ce_div ? (cyc % 4 == 0) : 1'b1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Full default-parameter transaction with CE held 1.
  // After edge k (k=0 is accept): CSB low k<=3, strobe low k=1..2, ACK at k=4.
  task automatic txn(input vec_t v);
    REQ = 1'b1; REQ_WE = v.we; REQ_A = v.a; REQ_D = v.d; DB_I = 8'h00;
    tick();
    REQ = 1'b0; REQ_A = ~v.a; REQ_D = ~v.d;
    for (int k = 0; k <= 4; k++) begin
      chk("csb",   CSB,   (k <= 3) ? 1'b0 : 1'b1);
      chk("wrb",   WRB,   (v.we && (k == 1 || k == 2)) ? 1'b0 : 1'b1);
      chk("rdb",   RDB,   (!v.we && (k == 1 || k == 2)) ? 1'b0 : 1'b1);
      chk("db_oe", DB_OE, (k <= 3) ? v.we : 1'b0);
      chk("busy",  BUSY,  (k <= 3) ? 1'b1 : 1'b0);
      chk("ack",   ACK,   (k == 4) ? 1'b1 : 1'b0);
      chk("addr",  A,     v.a);
      if (v.we) chk("db_o", DB_O, v.d);
      DB_I = (k == 2) ? v.dbi : 8'h00;
      if (k < 4) tick();
    end
    chk("rd_data", RD_DATA, v.exp_rd);
    tick();
    chk("ack_drop", ACK, 1'b0);
    chk("idle_csb", CSB, 1'b1);
  endtask

  initial begin
    int unsigned rdb_low, ack_n;

    vecs[0] = '{we: 1'b1, a: 13'h1400, d: 8'h5A, dbi: 8'h00, exp_rd: 8'h00};
    vecs[1] = '{we: 1'b0, a: 13'h0123, d: 8'h00, dbi: 8'hC3, exp_rd: 8'hC3};
    vecs[2] = '{we: 1'b1, a: 13'h1FFF, d: 8'hFF, dbi: 8'hEE, exp_rd: 8'hC3};
    vecs[3] = '{we: 1'b0, a: 13'h0AB0, d: 8'h00, dbi: 8'h3C, exp_rd: 8'h3C};

    RESB = 1'b0; CE = 1'b1; REQ = 1'b0; b_REQ = 1'b0; REQ_WE = 1'b0;
    REQ_A = '0; REQ_D = '0; DB_I = '0;
    tick(); tick();
    chk("rst_csb", CSB, 1'b1);  chk("rst_rdb", RDB, 1'b1);
    chk("rst_wrb", WRB, 1'b1);  chk("rst_oe", DB_OE, 1'b0);
    chk("rst_ack", ACK, 1'b0);  chk("rst_busy", BUSY, 1'b0);
    chk("rst_a", A, 13'h0);     chk("rst_dbo", DB_O, 8'h00);
    chk("rst_rd", RD_DATA, 8'h00);
    RESB = 1'b1;
    tick();

    for (int i = 0; i < 4; i++) txn(vecs[i]);

    // CE every 4th CLK; request arrives while CE=0.
    ce_div = 1'b1;
    for (int i = 0; i < 4 && CE; i++) tick();
    chk("ce_low_at_req", CE, 1'b0);
    REQ = 1'b1; REQ_WE = 1'b0; REQ_A = 13'h0042;
    tick();
    REQ = 1'b0;
    chk("ce_accept_busy", BUSY, 1'b1);
    chk("ce_accept_csb", CSB, 1'b0);
    rdb_low = 0; ack_n = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (!RDB) rdb_low++;
      if (ACK) ack_n++;
    end
    chk("ce_rdb_low_clks", rdb_low, 8);
    chk("ce_ack_width", ack_n, 1);
    chk("ce_end_busy", BUSY, 1'b0);
    ce_div = 1'b0; CE = 1'b1;

    // Back-to-back with REQ_A changed mid-transaction.
    REQ = 1'b1; REQ_WE = 1'b1; REQ_A = 13'h0AAA; REQ_D = 8'h11;
    tick();
    REQ_A = 13'h0555; REQ_D = 8'h22;
    chk("b2b_a0", A, 13'h0AAA);
    for (int k = 1; k <= 10; k++) begin
      tick();
      if (k == 3) begin chk("b2b_a3", A, 13'h0AAA); chk("b2b_csb3", CSB, 1'b0); end
      if (k == 4) begin chk("b2b_ack4", ACK, 1'b1); chk("b2b_csb4", CSB, 1'b1); chk("b2b_a4", A, 13'h0AAA); end
      if (k == 5) begin
        chk("b2b_csb5", CSB, 1'b0); chk("b2b_ack5", ACK, 1'b0);
        chk("b2b_a5", A, 13'h0555); chk("b2b_dbo5", DB_O, 8'h22);
      end
      if (k == 6) chk("b2b_wrb6", WRB, 1'b0);
      if (k == 9) begin chk("b2b_ack9", ACK, 1'b1); REQ = 1'b0; end
      if (k == 10) begin chk("b2b_csb10", CSB, 1'b1); chk("b2b_busy10", BUSY, 1'b0); end
    end

    // Reset during the write strobe.
    REQ = 1'b1; REQ_WE = 1'b1; REQ_A = 13'h1234; REQ_D = 8'h77;
    tick();
    REQ = 1'b0;
    tick();
    chk("mid_wrb_low", WRB, 1'b0);
    RESB = 1'b0;
    tick();
    chk("mid_rst_wrb", WRB, 1'b1); chk("mid_rst_csb", CSB, 1'b1);
    chk("mid_rst_busy", BUSY, 1'b0); chk("mid_rst_a", A, 13'h0);
    chk("mid_rst_ack", ACK, 1'b0); chk("mid_rst_rd", RD_DATA, 8'h00);
    RESB = 1'b1;
    tick();
    chk("post_rst_ack", ACK, 1'b0);
    txn('{we: 1'b1, a: 13'h0042, d: 8'h99, dbi: 8'h00, exp_rd: 8'h00});

    // 1/1/1 instance: strobe 1 cycle, ACK 3 cycles after accept.
    b_REQ = 1'b1; REQ_WE = 1'b1; REQ_A = 13'h0F0F; REQ_D = 8'h3C;
    tick();
    b_REQ = 1'b0;
    chk("b_csb0", b_CSB, 1'b0); chk("b_wrb0", b_WRB, 1'b1);
    tick();
    chk("b_wrb1", b_WRB, 1'b0); chk("b_a1", b_A, 13'h0F0F);
    tick();
    chk("b_wrb2", b_WRB, 1'b1); chk("b_ack2", b_ACK, 1'b0); chk("b_csb2", b_CSB, 1'b0);
    tick();
    chk("b_ack3", b_ACK, 1'b1); chk("b_csb3", b_CSB, 1'b1);
    tick();
    chk("b_ack4", b_ACK, 1'b0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
